// File: rtl/lr4_entry_disp.sv
// Hex digit entry buffer with delete/replace/clear editing and a strobe-driven
// multiplexed 7-segment scan. Digit 0 (the newest entry) is held in the low nibble of VALUE.
module lr4_entry_disp #(
  parameter int DIGITS    = 8,
  parameter int DAT_W     = 4,
  parameter bit FULL_MODE = 1'b0,
  parameter bit BLANK_EN  = 1'b1,
  localparam int CNT_W    = $clog2(DIGITS + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ENT_CE,
  input  logic                    DEL_CE,
  input  logic                    CLR_CE,
  input  logic                    DISP_CE,
  input  logic [DAT_W-1:0]        DAT_I,
  output logic [6:0]              CAT,
  output logic [DIGITS-1:0]       AN,
  output logic [DIGITS*DAT_W-1:0] VALUE,
  output logic [CNT_W-1:0]        COUNT,
  output logic                    FULL
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VAL_W = DIGITS * DAT_W;

  logic [VAL_W-1:0]  r_value;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic [IDX_W-1:0]  r_idx;
  logic              r_scan_on;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_cat;

  logic [VAL_W-1:0]  w_value_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [DAT_W-1:0]  w_digit;
  logic              w_blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      4'hF:    seg7 = 7'b0001110;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Edit priority: clear, then replace, then enter, then delete.
  always_comb begin
    w_value_nxt = r_value;
    w_count_nxt = r_count;
    if (CLR_CE) begin
      w_value_nxt = '0;
      w_count_nxt = '0;
    end else if (ENT_CE && DEL_CE && (r_count != '0)) begin
      w_value_nxt = {r_value[VAL_W-1:DAT_W], DAT_I};
    end else if (ENT_CE) begin
      if (!r_full) begin
        w_value_nxt = {r_value[VAL_W-DAT_W-1:0], DAT_I};
        w_count_nxt = r_count + CNT_W'(1);
      end else if (FULL_MODE) begin
        w_value_nxt = {r_value[VAL_W-DAT_W-1:0], DAT_I};
      end else begin
        w_value_nxt = r_value;
      end
    end else if (DEL_CE && (r_count != '0)) begin
      w_value_nxt = {{DAT_W{1'b0}}, r_value[VAL_W-1:DAT_W]};
      w_count_nxt = r_count - CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // The first strobe after reset lands on digit 0 rather than digit 1.
  always_comb begin
    w_idx_nxt = '0;
    if (!r_scan_on) begin
      w_idx_nxt = '0;
    end else if (r_idx == IDX_W'(DIGITS - 1)) begin
      w_idx_nxt = '0;
    end else begin
      w_idx_nxt = r_idx + IDX_W'(1);
    end
  end

  assign w_digit = r_value[w_idx_nxt*DAT_W +: DAT_W];
  assign w_blank = BLANK_EN && (CNT_W'(w_idx_nxt) >= r_count);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_value <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_value <= w_value_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DIGITS));
    end
  end

  // Scan registers see the pre-edit buffer, so an edit shows on the next visit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx     <= '0;
      r_scan_on <= 1'b0;
      r_an      <= '1;
      r_cat     <= 7'h7F;
    end else if (DISP_CE) begin
      r_idx     <= w_idx_nxt;
      r_scan_on <= 1'b1;
      r_an      <= ~(DIGITS'(1) << w_idx_nxt);
      r_cat     <= w_blank ? 7'h7F : seg7(w_digit);
    end else begin
      r_idx     <= r_idx;
      r_scan_on <= r_scan_on;
      r_an      <= r_an;
      r_cat     <= r_cat;
    end
  end

  assign VALUE = r_value;
  assign COUNT = r_count;
  assign FULL  = r_full;
  assign AN    = r_an;
  assign CAT   = r_cat;

endmodule

// File: tb/tb_lr4_entry_disp.sv
// Scoreboard bench: three configurations share stimulus; expectations are queued
// with a due cycle and a monitor compares them on the falling edge.
module tb_lr4_entry_disp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, ent = 1'b0, del = 1'b0, clr = 1'b0, disp = 1'b0;
  logic [3:0] dat = 4'h0;

  logic [6:0]  cat0, cat1, cat2;
  logic [7:0]  an0, an1;
  logic [3:0]  an2;
  logic [31:0] val0, val1;
  logic [15:0] val2;
  logic [3:0]  cnt0, cnt1;
  logic [2:0]  cnt2;
  logic        full0, full1, full2;

  lr4_entry_disp #(.DIGITS(8), .DAT_W(4), .FULL_MODE(1'b0), .BLANK_EN(1'b1)) u0 (
    .CLK(clk), .RST(rst), .ENT_CE(ent), .DEL_CE(del), .CLR_CE(clr), .DISP_CE(disp),
    .DAT_I(dat), .CAT(cat0), .AN(an0), .VALUE(val0), .COUNT(cnt0), .FULL(full0));
  lr4_entry_disp #(.DIGITS(8), .DAT_W(4), .FULL_MODE(1'b1), .BLANK_EN(1'b1)) u1 (
    .CLK(clk), .RST(rst), .ENT_CE(ent), .DEL_CE(del), .CLR_CE(clr), .DISP_CE(disp),
    .DAT_I(dat), .CAT(cat1), .AN(an1), .VALUE(val1), .COUNT(cnt1), .FULL(full1));
  lr4_entry_disp #(.DIGITS(4), .DAT_W(4), .FULL_MODE(1'b0), .BLANK_EN(1'b0)) u2 (
    .CLK(clk), .RST(rst), .ENT_CE(ent), .DEL_CE(del), .CLR_CE(clr), .DISP_CE(disp),
    .DAT_I(dat), .CAT(cat2), .AN(an2), .VALUE(val2), .COUNT(cnt2), .FULL(full2));

  typedef struct {
    int          due;
    int          dut;
    bit          scan;
    logic [31:0] value;
    int          count;
    bit          full;
    logic [7:0]  an;
    logic [6:0]  cat;
    string       name;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expectation that has come due and compare.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [31:0] av;
      int ac;
      bit af;
      logic [7:0] aan;
      logic [6:0] acat;
      e = q.pop_front();
      case (e.dut)
        0:       begin av = val0; ac = int'(cnt0); af = full0; aan = an0; acat = cat0; end
        1:       begin av = val1; ac = int'(cnt1); af = full1; aan = an1; acat = cat1; end
        default: begin av = {16'h0, val2}; ac = int'(cnt2); af = full2; aan = {4'h0, an2}; acat = cat2; end
      endcase
      n_cmp++;
      if (e.due != cyc) begin
        n_bad++;
        $display("FAIL %s: checked late at cycle %0d, due %0d", e.name, cyc, e.due);
      end else if (e.scan) begin
        if (aan !== e.an || acat !== e.cat) begin
          n_bad++;
          $display("FAIL %s: AN=%h CAT=%h, expected AN=%h CAT=%h", e.name, aan, acat, e.an, e.cat);
        end
      end else begin
        if (av !== e.value || ac != e.count || af !== e.full) begin
          n_bad++;
          $display("FAIL %s: VALUE=%h COUNT=%0d FULL=%b, expected VALUE=%h COUNT=%0d FULL=%b",
                   e.name, av, ac, af, e.value, e.count, e.full);
        end
      end
    end
  end

  task automatic drive(input bit r, input bit e, input bit d, input bit c, input bit s,
                       input logic [3:0] v);
    @(negedge clk);
    rst = r; ent = e; del = d; clr = c; disp = s; dat = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic exp_buf(input int dut, input string n, input logic [31:0] v, input int c,
                         input bit f);
    exp_t e;
    e = '{cyc + 1, dut, 1'b0, v, c, f, 8'h00, 7'h00, n};
    q.push_back(e);
  endtask

  task automatic exp_scan(input int dut, input string n, input logic [7:0] a, input logic [6:0] k);
    exp_t e;
    e = '{cyc + 1, dut, 1'b1, 32'h0, 0, 1'b0, a, k, n};
    q.push_back(e);
  endtask

  task automatic do_reset(input bit with_ent, input string n);
    drive(1'b1, with_ent, 1'b0, 1'b0, 1'b0, 4'h4);
    exp_buf(0, {n, "_buf0"}, 32'h0, 0, 1'b0);
    exp_buf(1, {n, "_buf1"}, 32'h0, 0, 1'b0);
    exp_buf(2, {n, "_buf2"}, 32'h0, 0, 1'b0);
    exp_scan(0, {n, "_scan0"}, 8'hFF, 7'h7F);
    exp_scan(1, {n, "_scan1"}, 8'hFF, 7'h7F);
    exp_scan(2, {n, "_scan2"}, 8'h0F, 7'h7F);
  endtask

  logic [3:0] an4_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  initial begin
    // 1: reset state, scan idle until first DISP_CE, then digit 0 blank
    do_reset(1'b0, "t1_rst");
    idle(2);
    exp_scan(0, "t1_pre", 8'hFF, 7'h7F);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    exp_scan(0, "t1_d0", 8'hFE, 7'h7F);
    exp_scan(2, "t1_u2_d0", 8'h0E, 7'h40);
    idle(3);
    exp_scan(0, "t1_hold", 8'hFE, 7'h7F);

    // 2: enter 1,2,3 and scan four digits (reset mid-scan restarts at digit 0)
    do_reset(1'b0, "t2_rst");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
    exp_buf(0, "t2_e1", 32'h1, 1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
    exp_buf(0, "t2_e3", 32'h123, 3, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    exp_scan(0, "t2_dig0", 8'hFE, 7'h30);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    exp_scan(0, "t2_dig1", 8'hFD, 7'h24);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    exp_scan(0, "t2_dig2", 8'hFB, 7'h79);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    exp_scan(0, "t2_dig3", 8'hF7, 7'h7F);
    idle(1);

    // 4: delete, replace, delete past empty
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    exp_buf(0, "t4_del", 32'h12, 2, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
    exp_buf(0, "t4_repl", 32'h1F, 2, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    exp_buf(0, "t4_del1", 32'h1, 1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    exp_buf(0, "t4_del2", 32'h0, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    exp_buf(0, "t4_under", 32'h0, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA);
    exp_buf(0, "t4_repl_empty", 32'hA, 1, 1'b0);
    idle(1);

    // 3: fill to full, then one more entry in both full modes
    do_reset(1'b0, "t3_rst");
    for (int i = 1; i <= 8; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(i));
    exp_buf(0, "t3_fill0", 32'h12345678, 8, 1'b1);
    exp_buf(1, "t3_fill1", 32'h12345678, 8, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
    exp_buf(0, "t3_full_ignore", 32'h12345678, 8, 1'b1);
    exp_buf(1, "t3_full_scroll", 32'h23456789, 8, 1'b1);
    idle(1);

    // edit and DISP_CE together: scan shows the pre-edit (empty) buffer
    do_reset(1'b0, "te_rst");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7);
    exp_buf(0, "te_buf", 32'h7, 1, 1'b0);
    exp_scan(0, "te_scan", 8'hFE, 7'h7F);
    idle(1);

    // 5: clear beats enter; reset beats enter
    do_reset(1'b0, "t5_rst");
    for (int i = 1; i <= 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(i));
    exp_buf(0, "t5_fill", 32'h12345, 5, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h9);
    exp_buf(0, "t5_clr", 32'h0, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4);
    exp_buf(0, "t5_ent", 32'h4, 1, 1'b0);
    do_reset(1'b1, "t5_rst_ent");

    // 6: four-digit unblanked scan, three full revolutions
    idle(1);
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      exp_scan(2, $sformatf("t6_scan%0d", k), {4'h0, an4_tab[k % 4]}, 7'h40);
      idle(1);
    end

    idle(3);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never checked, due cycle %0d, now %0d", e.name, e.due, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
